mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the pipeline's instruction-fetch port (IF) and its load/store port (DM).
- Sits between the pipeline (PC/IF_ID on one side, the EX_MEM/MEM_WB stage on the other) and the backing memory.
- Generates per-port stall signals used to gate PCWrite/IFIDWrite and to freeze the MEM stage.
- DM is favoured; a streak counter guarantees that IF makes forward progress.

---
 rtl/mem_port_arbiter.sv | 147 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates a single-port unified memory between instruction fetch (IF) and load/store (DM).
// DM is favoured; a streak counter forces an IF grant after too many DM wins.
module mem_port_arbiter #(
  parameter int MAX_DATA_STREAK = 4,
  parameter int TIMEOUT         = 64
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ready_o,
  output logic        if_stall_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [31:0] dm_addr_i,
  input  logic [31:0] dm_wdata_i,
  output logic [31:0] dm_rdata_o,
  output logic        dm_ready_o,
  output logic        dm_stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_ack_i,
  output logic        err_o
);

  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT} state_t;

  localparam logic [3:0] STREAK_MAX  = 4'(MAX_DATA_STREAK);
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_next;
  logic [3:0]  streak, streak_next;
  logic [7:0]  wait_cnt, wait_cnt_next;
  logic        mem_req_next, mem_we_next;
  logic [31:0] mem_addr_next, mem_wdata_next;
  logic [31:0] if_rdata_next, dm_rdata_next;
  logic        if_ready_next, dm_ready_next, err_next;
  logic        if_elig, dm_elig, grant_dm, grant_if, timed_out;

  assign if_stall_o = if_req_i & ~if_ready_o;
  assign dm_stall_o = dm_req_i & ~dm_ready_o;

  // A port whose ready pulse is out this cycle is still showing its finished request.
  assign if_elig   = if_req_i & ~if_ready_o;
  assign dm_elig   = dm_req_i & ~dm_ready_o;
  assign grant_dm  = dm_elig & (~if_elig | (streak < STREAK_MAX));
  assign grant_if  = if_elig & ~grant_dm;
  assign timed_out = (TIMEOUT != 0) && (wait_cnt == TIMEOUT_CNT);

  always_comb begin
    state_next     = state;
    streak_next    = streak;
    wait_cnt_next  = wait_cnt;
    mem_req_next   = mem_req_o;
    mem_we_next    = mem_we_o;
    mem_addr_next  = mem_addr_o;
    mem_wdata_next = mem_wdata_o;
    if_rdata_next  = if_rdata_o;
    dm_rdata_next  = dm_rdata_o;
    if_ready_next  = 1'b0;
    dm_ready_next  = 1'b0;
    err_next       = err_o;

    case (state)
      IDLE: begin
        if (grant_dm) begin
          state_next     = DM_WAIT;
          mem_req_next   = 1'b1;
          mem_we_next    = dm_we_i;
          mem_addr_next  = dm_addr_i;
          mem_wdata_next = dm_wdata_i;
          wait_cnt_next  = '0;
          if (!if_req_i)
            streak_next = '0;
          else if (streak != 4'hF)
            streak_next = streak + 4'd1;
        end else if (grant_if) begin
          state_next     = IF_WAIT;
          mem_req_next   = 1'b1;
          mem_we_next    = 1'b0;
          mem_addr_next  = if_addr_i;
          mem_wdata_next = '0;
          wait_cnt_next  = '0;
          streak_next    = '0;
        end
      end
      IF_WAIT, DM_WAIT: begin
        // An abort completes the port with zero data and latches the error.
        if (mem_ack_i || timed_out) begin
          state_next   = IDLE;
          mem_req_next = 1'b0;
          mem_we_next  = 1'b0;
          if (!mem_ack_i)
            err_next = 1'b1;
          if (state == IF_WAIT) begin
            if_ready_next = 1'b1;
            if_rdata_next = mem_ack_i ? mem_rdata_i : '0;
          end else begin
            dm_ready_next = 1'b1;
            if (!mem_ack_i)
              dm_rdata_next = '0;
            else if (!mem_we_o)
              dm_rdata_next = mem_rdata_i;
          end
        end else begin
          wait_cnt_next = wait_cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      streak      <= '0;
      wait_cnt    <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      if_rdata_o  <= '0;
      dm_rdata_o  <= '0;
      if_ready_o  <= 1'b0;
      dm_ready_o  <= 1'b0;
      err_o       <= 1'b0;
    end else begin
      state       <= state_next;
      streak      <= streak_next;
      wait_cnt    <= wait_cnt_next;
      mem_req_o   <= mem_req_next;
      mem_we_o    <= mem_we_next;
      mem_addr_o  <= mem_addr_next;
      mem_wdata_o <= mem_wdata_next;
      if_rdata_o  <= if_rdata_next;
      dm_rdata_o  <= dm_rdata_next;
      if_ready_o  <= if_ready_next;
      dm_ready_o  <= dm_ready_next;
      err_o       <= err_next;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level model of the arbiter and memory.
module tb_mem_port_arbiter;

  localparam int MAX_STREAK = 4;
  localparam int TMO        = 8;

  logic        clk_i, rst_i;
  logic        if_req_i, if_ready_o, if_stall_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        dm_req_i, dm_we_i, dm_ready_o, dm_stall_o;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic        mem_req_o, mem_we_o, mem_ack_i, err_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

  mem_port_arbiter #(.MAX_DATA_STREAK(MAX_STREAK), .TIMEOUT(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o),
    .if_ready_o(if_ready_o), .if_stall_o(if_stall_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
    .dm_rdata_o(dm_rdata_o), .dm_ready_o(dm_ready_o), .dm_stall_o(dm_stall_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
    .err_o(err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Model of the arbiter: owner 0 = nobody, 1 = IF, 2 = DM.
  int          owner, streak, txn_cycles;
  logic        m_req, m_we, m_if_ready, m_dm_ready, m_err;
  logic [31:0] m_addr, m_wdata, m_if_rdata, m_dm_rdata;

  // Backing memory environment; env_delay < 0 selects random ack latency.
  logic [31:0] mem_arr [logic [31:0]];
  int          env_delay, env_left;
  bit          env_busy, env_idle_ack;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] memRead(input logic [31:0] a);
    if (mem_arr.exists(a)) return mem_arr[a];
    return a ^ 32'hA5A5_0000;
  endfunction

  function automatic logic [31:0] rndAddr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  task automatic modelReset();
    owner = 0; streak = 0; txn_cycles = 0;
    m_req = 0; m_we = 0; m_if_ready = 0; m_dm_ready = 0; m_err = 0;
    m_addr = 0; m_wdata = 0; m_if_rdata = 0; m_dm_rdata = 0;
  endtask

  task automatic modelStep(input logic rst, input logic ir, input logic [31:0] ia,
                           input logic dr, input logic dw, input logic [31:0] da,
                           input logic [31:0] dwd, input logic ack, input logic [31:0] rd);
    bit want_if, want_dm;
    want_if = ir && !m_if_ready;
    want_dm = dr && !m_dm_ready;
    m_if_ready = 0;
    m_dm_ready = 0;
    if (!rst) begin
      modelReset();
      return;
    end
    if (owner == 0) begin
      if (want_dm && (!want_if || streak < MAX_STREAK)) begin
        owner = 2; m_req = 1; m_we = dw; m_addr = da; m_wdata = dwd; txn_cycles = 0;
        if (!ir) streak = 0;
        else if (streak < MAX_STREAK) streak++;
      end else if (want_if) begin
        owner = 1; m_req = 1; m_we = 0; m_addr = ia; txn_cycles = 0; streak = 0;
      end
    end else begin
      txn_cycles++;
      if (ack || (TMO != 0 && txn_cycles == TMO + 1)) begin
        if (!ack) m_err = 1;
        if (owner == 1) begin
          m_if_ready = 1;
          m_if_rdata = ack ? rd : 32'h0;
        end else begin
          m_dm_ready = 1;
          if (!ack) m_dm_rdata = 32'h0;
          else if (!m_we) m_dm_rdata = rd;
        end
        owner = 0; m_req = 0; m_we = 0;
      end
    end
  endtask

  // Called at a falling edge: check this cycle's outputs, drive inputs, advance the model.
  task automatic applyStimulus(input logic rst, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dwd);
    logic        ack;
    logic [31:0] rd;
    checkOutput("ctl", 64'({mem_req_o, mem_we_o, if_ready_o, dm_ready_o, err_o}),
                64'({m_req, m_we, m_if_ready, m_dm_ready, m_err}));
    if (m_req) checkOutput("mem_addr", 64'(mem_addr_o), 64'(m_addr));
    if (m_we)  checkOutput("mem_wdata", 64'(mem_wdata_o), 64'(m_wdata));
    checkOutput("if_rdata", 64'(if_rdata_o), 64'(m_if_rdata));
    checkOutput("dm_rdata", 64'(dm_rdata_o), 64'(m_dm_rdata));

    ack = 1'b0;
    rd  = $urandom;
    if (m_req) begin
      if (!env_busy) begin
        env_busy = 1'b1;
        if (env_delay >= 0) env_left = env_delay;
        else env_left = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 3));
      end
      if (env_left == 0) begin
        ack = 1'b1;
        if (m_we) mem_arr[m_addr] = m_wdata;
        else rd = memRead(m_addr);
      end else begin
        env_left--;
      end
    end else begin
      env_busy = 1'b0;
      ack = env_idle_ack ? 1'b1 : ($urandom_range(0, 5) == 0);
    end

    rst_i = rst; if_req_i = ir; if_addr_i = ia;
    dm_req_i = dr; dm_we_i = dw; dm_addr_i = da; dm_wdata_i = dwd;
    mem_ack_i = ack; mem_rdata_i = rd;
    #1;
    checkOutput("stall", 64'({if_stall_o, dm_stall_o}),
                64'({ir & ~m_if_ready, dr & ~m_dm_ready}));
    modelStep(rst, ir, ia, dr, dw, da, dwd, ack, rd);
    @(negedge clk_i);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic runDm(input logic we, input logic [31:0] addr, input logic [31:0] wd);
    bit done;
    int cycles;
    done = 0;
    cycles = 0;
    while (!done && cycles < 60) begin
      done = (cycles > 0) && m_dm_ready;
      applyStimulus(1, 0, 32'h0, 1, we, addr, wd);
      cycles++;
    end
    checkOutput("dm_done", 64'(done), 64'(1));
  endtask

  task automatic runRandom(input int n);
    bit          dm_pend, fin;
    logic        dwe;
    logic [31:0] dad, dwd;
    dm_pend = 0; dwe = 0; dad = 0; dwd = 0;
    for (int c = 0; c < n; c++) begin
      if (!dm_pend && $urandom_range(0, 2) == 0) begin
        dm_pend = 1;
        dwe = 1'($urandom_range(0, 1));
        dad = rndAddr();
        dwd = $urandom;
      end
      fin = m_dm_ready;
      applyStimulus(logic'($urandom_range(0, 399) != 0), logic'($urandom_range(0, 3) != 0),
                    rndAddr(), dm_pend, dwe, dad, dwd);
      if (fin) dm_pend = 0;
    end
  endtask

  initial begin
    int rise, rdy, if_pulses;
    env_delay = 0; env_left = 0; env_busy = 0; env_idle_ack = 0;
    rst_i = 0; if_req_i = 0; if_addr_i = 0; dm_req_i = 0; dm_we_i = 0;
    dm_addr_i = 0; dm_wdata_i = 0; mem_ack_i = 0; mem_rdata_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    modelReset();
    checkOutput("reset_ctl", 64'({mem_req_o, mem_we_o, if_ready_o, dm_ready_o, err_o}), 64'(0));
    checkOutput("reset_rdata", {if_rdata_o, dm_rdata_o}, 64'(0));

    $display("[TB] single fetch");
    env_delay = 1;
    mem_arr[32'h10] = 32'h8C220004;
    for (int c = 0; c < 4; c++) begin
      if (c == 3) checkOutput("if_ready_cycle3", 64'(if_ready_o), 64'(1));
      applyStimulus(1, 1, 32'h10, 0, 0, 32'h0, 32'h0);
    end
    checkOutput("if_rdata_fetch", 64'(if_rdata_o), 64'(32'h8C220004));
    idleCycles(2);

    $display("[TB] store then load");
    env_delay = 0;
    mem_arr[32'h44] = 32'h11112222;
    runDm(0, 32'h44, 32'h0);
    idleCycles(1);
    runDm(1, 32'h40, 32'hCAFEF00D);
    checkOutput("store_keeps_rdata", 64'(dm_rdata_o), 64'(32'h11112222));
    idleCycles(1);
    runDm(0, 32'h40, 32'h0);
    checkOutput("load_after_store", 64'(dm_rdata_o), 64'(32'hCAFEF00D));
    idleCycles(2);

    $display("[TB] contention");
    for (int c = 0; c < 40; c++) applyStimulus(1, 1, 32'h1000, 1, 0, 32'h2000, 32'h0);
    idleCycles(3);

    $display("[TB] timeout");
    env_delay = 20;
    rise = -1;
    rdy = -1;
    for (int c = 0; c < 30; c++) begin
      if (mem_req_o && rise < 0) rise = c;
      if (dm_ready_o && rdy < 0) rdy = c;
      applyStimulus(1, 0, 32'h0, logic'(rdy < 0 || rdy == c), 0, 32'h80, 32'h0);
    end
    checkOutput("timeout_latency", 64'(rdy - rise), 64'(9));
    checkOutput("timeout_rdata", 64'(dm_rdata_o), 64'(0));
    env_idle_ack = 1;
    idleCycles(3);
    env_idle_ack = 0;
    checkOutput("err_sticky", 64'({err_o, mem_req_o}), 64'(2'b10));

    $display("[TB] reset mid-transaction");
    for (int c = 0; c < 4; c++) applyStimulus(1, 0, 32'h0, 1, 0, 32'h84, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 32'h84, 32'h0);
    checkOutput("reset_mid", 64'({mem_req_o, if_ready_o, dm_ready_o, err_o}), 64'(0));
    env_delay = 0;
    runDm(0, 32'h84, 32'h0);
    checkOutput("after_reset_load", 64'(dm_rdata_o), 64'(32'h84 ^ 32'hA5A5_0000));
    idleCycles(2);

    $display("[TB] fetch flush");
    env_delay = 3;
    if_pulses = 0;
    for (int c = 0; c < 10; c++) begin
      if (if_ready_o) if_pulses++;
      applyStimulus(1, logic'(c < 2), 32'h20, 0, 0, 32'h0, 32'h0);
    end
    checkOutput("flush_pulses", 64'(if_pulses), 64'(1));
    checkOutput("flush_idle", 64'(mem_req_o), 64'(0));

    $display("[TB] random traffic");
    env_delay = -1;
    runRandom(1500);
    idleCycles(30);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
